// File: rtl/scan_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the scan controller.
package scan_ctrl_pkg;

   localparam logic [7:0] CMD_MOVE_RANGE = 8'hF0;
   localparam logic [7:0] CMD_MOVE       = 8'hF1;

   localparam logic [7:0] ST_OK      = 8'hA0;
   localparam logic [7:0] ST_TIMEOUT = 8'hAE;

   typedef enum logic [2:0] {
      IDLE,
      RX_POS,
      SETTLE,
      TRIG,
      WAIT_ECHO,
      MEASURE,
      REPLY
   } state_e;

   // Saturate a received position byte at the mechanical limit.
   function automatic logic [7:0] clamp_pos(input logic [7:0] b, input logic [7:0] max);
      return (b > max) ? max : b;
   endfunction

endpackage

// File: rtl/scan_ctrl_servo_pwm.sv
// One servo channel: shadow/active position pair and pulse comparator.
// The active position only changes at the frame wrap, so a pulse in
// flight is never cut short or stretched.
module servo_pwm #(
   parameter int PULSE_BASE_CYC = 25_000,
   parameter int PULSE_STEP_CYC = 555,
   parameter int POS_RESET      = 90
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic [31:0] cnt_i,
   input  logic        wrap_i,
   input  logic        ld_i,
   input  logic [7:0]  pos_i,
   output logic        servo_o
);

   logic [7:0]  shadow_q;
   logic [7:0]  active_q;
   logic [31:0] width;

   // Shadow takes commits at any time; active follows it at the wrap.
   // A commit landing on the wrap cycle goes straight to active.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         shadow_q <= 8'(POS_RESET);
         active_q <= 8'(POS_RESET);
      end else begin
         if (ld_i)   shadow_q <= pos_i;
         if (wrap_i) active_q <= ld_i ? pos_i : shadow_q;
      end
   end

   assign width   = 32'(PULSE_BASE_CYC) + 32'(active_q) * 32'(PULSE_STEP_CYC);
   assign servo_o = (cnt_i < width);

endmodule

// File: rtl/scan_ctrl.sv
// Command-frame decoder driving NUM_SERVO PWM channels, one-shot
// ultrasonic ranging and a 4-byte UART result frame.
module scan_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter int NUM_SERVO        = 2,
   parameter int SERVO_PERIOD_CYC = 1_000_000,
   parameter int PULSE_BASE_CYC   = 25_000,
   parameter int PULSE_STEP_CYC   = 555,
   parameter int POS_MAX          = 180,
   parameter int POS_RESET        = 90,
   parameter int SETTLE_CYC       = 500_000,
   parameter int TRIG_CYC         = 500,
   parameter int ECHO_TIMEOUT_CYC = 2_000_000,
   parameter int BYTE_TIMEOUT_CYC = 50_000,
   parameter int CNT_W            = 24
) (
   input  logic                 clk,
   input  logic                 rst_i,
   input  logic [7:0]           rx_data,
   input  logic                 rx_new,
   output logic [7:0]           tx_data,
   output logic                 tx_new,
   input  logic                 tx_busy,
   output logic [NUM_SERVO-1:0] servo,
   input  logic                 cap_sig,
   output logic                 trig,
   output logic                 busy
);

   localparam int               IDXW      = (NUM_SERVO > 1) ? $clog2(NUM_SERVO) : 1;
   localparam logic [IDXW-1:0]  IDX_LAST  = IDXW'(NUM_SERVO - 1);
   localparam logic [7:0]       POS_MAX_B = 8'(POS_MAX);

   // ---------------- shared PWM frame counter ----------------
   logic [31:0] fcnt_q, fcnt_d;
   logic        wrap;

   assign wrap   = (fcnt_q == 32'(SERVO_PERIOD_CYC - 1));
   assign fcnt_d = wrap ? '0 : fcnt_q + 32'd1;

   // Free-running frame counter, restarted by reset.
   always_ff @(posedge clk) begin
      if (rst_i) fcnt_q <= '0;
      else       fcnt_q <= fcnt_d;
   end

   // ---------------- echo synchroniser ----------------
   logic [1:0] sync_q;
   logic       echo;

   // Two-flop synchroniser for the asynchronous echo pin.
   always_ff @(posedge clk) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= {sync_q[0], cap_sig};
   end

   assign echo = sync_q[1];

   // ---------------- FSM state ----------------
   state_e                         state_q, state_d;
   logic                           mode_q, mode_d;      // 1 = range after move
   logic [IDXW-1:0]                idx_q, idx_d;
   logic [NUM_SERVO-1:0][7:0]      stage_q, stage_d;
   logic [31:0]                    tmr_q, tmr_d;        // settle/trig/gap/echo timer
   logic [CNT_W-1:0]               meas_q, meas_d;
   logic [7:0]                     status_q, status_d;
   logic [23:0]                    res_q, res_d;
   logic [1:0]                     bidx_q, bidx_d;
   logic                           tx_new_q, tx_new_d;
   logic [7:0]                     tx_data_q, tx_data_d;
   logic                           trig_q, trig_d;
   logic                           commit;
   logic [7:0]                     reply_byte;

   // Select the reply byte for the current index, MSB of result first.
   always_comb begin
      reply_byte = res_q[7:0];
      case (bidx_q)
         2'd0:    reply_byte = status_q;
         2'd1:    reply_byte = res_q[23:16];
         2'd2:    reply_byte = res_q[15:8];
         default: reply_byte = res_q[7:0];
      endcase
   end

   // Next-state and datapath decisions for the frame/ranging sequence.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      idx_d     = idx_q;
      stage_d   = stage_q;
      tmr_d     = tmr_q + 32'd1;
      meas_d    = meas_q;
      status_d  = status_q;
      res_d     = res_q;
      bidx_d    = bidx_q;
      tx_new_d  = 1'b0;
      tx_data_d = tx_data_q;
      commit    = 1'b0;

      case (state_q)
         IDLE: begin
            tmr_d = '0;
            if (rx_new && (rx_data == CMD_MOVE_RANGE || rx_data == CMD_MOVE)) begin
               mode_d  = (rx_data == CMD_MOVE_RANGE);
               idx_d   = '0;
               state_d = RX_POS;
            end
         end
         RX_POS: begin
            if (rx_new) begin
               stage_d[idx_q] = clamp_pos(rx_data, POS_MAX_B);
               tmr_d          = '0;
               if (idx_q == IDX_LAST) begin
                  commit  = 1'b1;
                  state_d = mode_q ? SETTLE : IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else if (tmr_q >= 32'(BYTE_TIMEOUT_CYC)) begin
               state_d = IDLE;            // stalled frame: discard, no commit
            end
         end
         SETTLE: begin
            if (tmr_q == 32'(SETTLE_CYC - 1)) begin
               tmr_d   = '0;
               state_d = TRIG;
            end
         end
         TRIG: begin
            if (tmr_q == 32'(TRIG_CYC - 1)) begin
               tmr_d   = '0;              // timeout window starts here
               state_d = WAIT_ECHO;
            end
         end
         WAIT_ECHO: begin
            meas_d = '0;
            if (tmr_q >= 32'(ECHO_TIMEOUT_CYC - 1)) begin
               status_d = ST_TIMEOUT;
               res_d    = 24'({CNT_W{1'b1}});
               bidx_d   = '0;
               state_d  = REPLY;
            end else if (echo) begin
               meas_d  = CNT_W'(1);       // this high cycle already counts
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (!echo) begin
               status_d = ST_OK;
               res_d    = 24'(meas_q);
               bidx_d   = '0;
               state_d  = REPLY;
            end else if (tmr_q >= 32'(ECHO_TIMEOUT_CYC - 1)) begin
               status_d = ST_TIMEOUT;
               res_d    = 24'({CNT_W{1'b1}});
               bidx_d   = '0;
               state_d  = REPLY;
            end else begin
               meas_d = meas_q + CNT_W'(1);
            end
         end
         REPLY: begin
            // The gap after each strobe gives the UART a cycle to raise busy.
            if (!tx_new_q && !tx_busy) begin
               tx_new_d  = 1'b1;
               tx_data_d = reply_byte;
               bidx_d    = bidx_q + 2'd1;
               if (bidx_q == 2'd3) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      trig_d = (state_d == TRIG);
   end

   // FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q   <= IDLE;
         mode_q    <= 1'b0;
         idx_q     <= '0;
         stage_q   <= '0;
         tmr_q     <= '0;
         meas_q    <= '0;
         status_q  <= '0;
         res_q     <= '0;
         bidx_q    <= '0;
         tx_new_q  <= 1'b0;
         tx_data_q <= '0;
         trig_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         idx_q     <= idx_d;
         stage_q   <= stage_d;
         tmr_q     <= tmr_d;
         meas_q    <= meas_d;
         status_q  <= status_d;
         res_q     <= res_d;
         bidx_q    <= bidx_d;
         tx_new_q  <= tx_new_d;
         tx_data_q <= tx_data_d;
         trig_q    <= trig_d;
      end
   end

   // ---------------- servo channels ----------------
   for (genvar i = 0; i < NUM_SERVO; i++) begin : g_ch
      servo_pwm #(
         .PULSE_BASE_CYC (PULSE_BASE_CYC),
         .PULSE_STEP_CYC (PULSE_STEP_CYC),
         .POS_RESET      (POS_RESET)
      ) u_pwm (
         .clk     (clk),
         .rst_i   (rst_i),
         .cnt_i   (fcnt_q),
         .wrap_i  (wrap),
         .ld_i    (commit),
         .pos_i   (stage_d[i]),
         .servo_o (servo[i])
      );
   end

   assign tx_new  = tx_new_q;
   assign tx_data = tx_data_q;
   assign trig    = trig_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl with shortened timing parameters.
module tb_scan_ctrl;

   localparam int NS     = 2;
   localparam int PER    = 5000;
   localparam int BASE   = 100;
   localparam int STEP   = 10;
   localparam int SETTLE = 200;
   localparam int ETO    = 20000;
   localparam int BTO    = 2000;
   localparam int TRIGC  = 500;
   localparam int HI_WIN = 2000;

   logic          clk     = 1'b0;
   logic          rst_i   = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_new  = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_new;
   logic          tx_busy = 1'b0;
   logic [NS-1:0] servo;
   logic          cap_sig = 1'b0;
   logic          trig;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] txq[$];
   int   tx_cnt = 0, tx_viol = 0, busy_left = 0, tx_first_cyc = 0;
   logic tx_prev = 1'b0;
   int   trig_hi = 0, trig_rise = -1;
   logic trig_prev = 1'b0;
   int   exp_pos[NS];
   int   last_cyc = 0;

   scan_ctrl #(
      .NUM_SERVO        (NS),
      .SERVO_PERIOD_CYC (PER),
      .PULSE_BASE_CYC   (BASE),
      .PULSE_STEP_CYC   (STEP),
      .SETTLE_CYC       (SETTLE),
      .ECHO_TIMEOUT_CYC (ETO),
      .BYTE_TIMEOUT_CYC (BTO)
   ) dut (
      .clk     (clk),
      .rst_i   (rst_i),
      .rx_data (rx_data),
      .rx_new  (rx_new),
      .tx_data (tx_data),
      .tx_new  (tx_new),
      .tx_busy (tx_busy),
      .servo   (servo),
      .cap_sig (cap_sig),
      .trig    (trig),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // UART tx responder (busy 30 cycles per byte) plus trig observer.
   always @(negedge clk) begin
      if (tx_new) begin
         if (txq.size() == 0) tx_first_cyc = cyc;
         txq.push_back(tx_data);
         tx_cnt++;
         if (tx_busy || tx_prev) tx_viol++;
         tx_busy   = 1'b1;
         busy_left = 30;
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) tx_busy = 1'b0;
      end
      tx_prev = tx_new;
      if (trig) trig_hi++;
      if (trig && !trig_prev) trig_rise = cyc;
      trig_prev = trig;
   end

   // Reference: pulse width from a commanded position.
   function automatic int exp_width(input int p);
      return BASE + ((p > 180) ? 180 : p) * STEP;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_new  = 1'b1;
      @(negedge clk);
      rx_new   = 1'b0;
      last_cyc = cyc;
   endtask

   task automatic send_frame(input logic [7:0] h, input logic [7:0] p0, input logic [7:0] p1);
      send_byte(h);
      send_byte(p0);
      send_byte(p1);
   endtask

   task automatic wait_rise(output bit ok);
      logic prev;
      ok = 1'b0;
      @(negedge clk);
      prev = servo[0];
      for (int i = 0; i < 2 * PER; i++) begin
         @(negedge clk);
         if (servo[0] && !prev) begin
            ok = 1'b1;
            break;
         end
         prev = servo[0];
      end
   endtask

   task automatic count_hi(output int h0, output int h1);
      h0 = 0;
      h1 = 0;
      for (int k = 0; k < HI_WIN; k++) begin
         if (k > 0) @(negedge clk);
         h0 += int'(servo[0]);
         h1 += int'(servo[1]);
      end
   endtask

   task automatic wait_trig_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (trig_rise >= 0 && !trig) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_reply(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (txq.size() >= 4) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_echo(input int w);
      repeat (20) @(negedge clk);
      cap_sig = 1'b1;
      repeat (w) @(negedge clk);
      cap_sig = 1'b0;
   endtask

   task automatic test_reset;
      int   h[2][2];
      logic any_tx, any_trig, any_busy;
      h = '{'{0, 0}, '{0, 0}};
      any_tx = 1'b0; any_trig = 1'b0; any_busy = 1'b0;
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      txq.delete();
      rst_i = 1'b0;
      total++;
      if (servo !== 2'b11) begin bad++; $display("FAIL reset_servo_high: got %b want 11", servo); end
      total++;
      if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      for (int k = 0; k < 2 * PER; k++) begin
         if (k > 0) @(negedge clk);
         h[k / PER][0] += int'(servo[0]);
         h[k / PER][1] += int'(servo[1]);
         any_tx   |= tx_new;
         any_trig |= trig;
         any_busy |= busy;
      end
      for (int f = 0; f < 2; f++)
         for (int c = 0; c < NS; c++) begin
            total++;
            if (h[f][c] !== exp_width(90)) begin
               bad++; $display("FAIL reset_width f%0d c%0d: got %0d want %0d", f, c, h[f][c], exp_width(90));
            end
         end
      total++;
      if (any_tx !== 1'b0) begin bad++; $display("FAIL reset_no_tx: got %b want 0", any_tx); end
      total++;
      if (any_trig !== 1'b0) begin bad++; $display("FAIL reset_no_trig: got %b want 0", any_trig); end
      total++;
      if (any_busy !== 1'b0) begin bad++; $display("FAIL reset_not_busy: got %b want 0", any_busy); end
      exp_pos[0] = 90;
      exp_pos[1] = 90;
   endtask

   task automatic test_move;
      bit ok;
      int h0, h1, n0;
      n0 = tx_cnt;
      wait_rise(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL move_rise1: got timeout want rise"); end
      fork
         count_hi(h0, h1);
         begin
            repeat (300) @(negedge clk);
            send_frame(8'hF1, 8'd150, 8'd30);
         end
      join
      total++;
      if (h0 !== exp_width(exp_pos[0]) || h1 !== exp_width(exp_pos[1])) begin
         bad++; $display("FAIL move_inflight: got %0d/%0d want %0d/%0d", h0, h1, exp_width(exp_pos[0]), exp_width(exp_pos[1]));
      end
      exp_pos[0] = 150;
      exp_pos[1] = 30;
      wait_rise(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL move_rise2: got timeout want rise"); end
      count_hi(h0, h1);
      total++;
      if (h0 !== exp_width(exp_pos[0])) begin bad++; $display("FAIL move_servo0: got %0d want %0d", h0, exp_width(exp_pos[0])); end
      total++;
      if (h1 !== exp_width(exp_pos[1])) begin bad++; $display("FAIL move_servo1: got %0d want %0d", h1, exp_width(exp_pos[1])); end
      total++;
      if (tx_cnt !== n0) begin bad++; $display("FAIL move_no_reply: got %0d bytes want 0", tx_cnt - n0); end
   endtask

   // Move + range; checks trigger timing and the measured echo reply.
   task automatic run_range(input string nm, input int p0, input int p1, input int w);
      bit ok;
      int c0, res;
      txq.delete();
      trig_hi   = 0;
      trig_rise = -1;
      tx_viol   = 0;
      send_frame(8'hF0, 8'(p0), 8'(p1));
      c0 = last_cyc;
      exp_pos[0] = p0;
      exp_pos[1] = p1;
      wait_trig_done(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL %s_trig: got timeout want pulse", nm); end
      total++;
      if (trig_rise - c0 !== SETTLE) begin bad++; $display("FAIL %s_trig_delay: got %0d want %0d", nm, trig_rise - c0, SETTLE); end
      total++;
      if (trig_hi !== TRIGC) begin bad++; $display("FAIL %s_trig_width: got %0d want %0d", nm, trig_hi, TRIGC); end
      pulse_echo(w);
      wait_reply(2000, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL %s_reply: got %0d bytes want 4", nm, txq.size());
      end else begin
         res = (int'(txq[1]) << 16) | (int'(txq[2]) << 8) | int'(txq[3]);
         total++;
         if (txq[0] !== 8'hA0) begin bad++; $display("FAIL %s_status: got %h want a0", nm, txq[0]); end
         total++;
         if (res < w - 1 || res > w + 1) begin bad++; $display("FAIL %s_result: got %0d want %0d+-1", nm, res, w); end
      end
      total++;
      if (tx_viol !== 0) begin bad++; $display("FAIL %s_tx_handshake: got %0d violations want 0", nm, tx_viol); end
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle: got busy=%b want 0", nm, busy); end
   endtask

   task automatic test_range;
      bit ok;
      int h0, h1;
      run_range("range", 200, 0, 1234);
      wait_rise(ok);
      count_hi(h0, h1);
      total++;
      if (h0 !== 1900) begin bad++; $display("FAIL range_servo0_clamp: got %0d want 1900", h0); end
      total++;
      if (h1 !== exp_width(0)) begin bad++; $display("FAIL range_servo1: got %0d want %0d", h1, exp_width(0)); end
   endtask

   task automatic test_timeout;
      bit ok;
      int c0;
      txq.delete();
      tx_viol = 0;
      cap_sig = 1'b0;
      send_frame(8'hF0, 8'd90, 8'd90);
      c0 = last_cyc;
      exp_pos[0] = 90;
      exp_pos[1] = 90;
      wait_reply(SETTLE + TRIGC + ETO + 500, ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL timeout_reply: got %0d bytes want 4", txq.size());
      end else begin
         total++;
         if ({txq[0], txq[1], txq[2], txq[3]} !== 32'hAEFFFFFF) begin
            bad++; $display("FAIL timeout_bytes: got %h %h %h %h want ae ff ff ff", txq[0], txq[1], txq[2], txq[3]);
         end
         total++;
         if (tx_first_cyc - c0 < SETTLE + TRIGC + ETO || tx_first_cyc - c0 > SETTLE + TRIGC + ETO + 5) begin
            bad++; $display("FAIL timeout_latency: got %0d want ~%0d", tx_first_cyc - c0, SETTLE + TRIGC + ETO);
         end
      end
      total++;
      if (tx_viol !== 0) begin bad++; $display("FAIL timeout_tx_handshake: got %0d want 0", tx_viol); end
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_random;
      for (int r = 0; r < 2; r++)
         run_range($sformatf("rand%0d", r), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(50, 3000)));
   endtask

   task automatic test_drop;
      bit ok;
      int h0, h1;
      trig_rise = -1;
      send_byte(8'hF0);
      send_byte(8'($urandom_range(0, 180)));
      repeat (BTO + 1000) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle: got busy=%b want 0", busy); end
      send_byte(8'd20);
      repeat (5) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL drop_late_byte: got busy=%b want 0", busy); end
      total++;
      if (trig_rise !== -1) begin bad++; $display("FAIL drop_no_trig: got rise at %0d want none", trig_rise); end
      wait_rise(ok);
      count_hi(h0, h1);
      total++;
      if (h0 !== exp_width(exp_pos[0]) || h1 !== exp_width(exp_pos[1])) begin
         bad++; $display("FAIL drop_positions: got %0d/%0d want %0d/%0d", h0, h1, exp_width(exp_pos[0]), exp_width(exp_pos[1]));
      end
   endtask

   task automatic test_reset_mid;
      bit   ok;
      int   h0, h1, n0, p0, p1;
      logic any_busy;
      trig_rise = -1;
      send_frame(8'hF0, 8'($urandom_range(0, 180)), 8'($urandom_range(0, 180)));
      wait_trig_done(ok);
      repeat (20) @(negedge clk);
      cap_sig = 1'b1;
      repeat (50) @(negedge clk);
      n0 = tx_cnt;
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      total++;
      if (trig !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_outputs: got trig=%b busy=%b want 0 0", trig, busy); end
      any_busy = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i == 100) cap_sig = 1'b0;
         any_busy |= busy;
      end
      total++;
      if (tx_cnt !== n0 || any_busy !== 1'b0) begin
         bad++; $display("FAIL rstmid_quiet: got %0d bytes busy=%b want 0 0", tx_cnt - n0, any_busy);
      end
      exp_pos[0] = 90;
      exp_pos[1] = 90;
      wait_rise(ok);
      count_hi(h0, h1);
      total++;
      if (h0 !== exp_width(90) || h1 !== exp_width(90)) begin
         bad++; $display("FAIL rstmid_positions: got %0d/%0d want %0d/%0d", h0, h1, exp_width(90), exp_width(90));
      end
      p0 = int'($urandom_range(0, 255));
      p1 = int'($urandom_range(0, 255));
      send_frame(8'hF1, 8'(p0), 8'(p1));
      exp_pos[0] = p0;
      exp_pos[1] = p1;
      wait_rise(ok);
      count_hi(h0, h1);
      total++;
      if (h0 !== exp_width(p0) || h1 !== exp_width(p1)) begin
         bad++; $display("FAIL rstmid_new_frame: got %0d/%0d want %0d/%0d", h0, h1, exp_width(p0), exp_width(p1));
      end
   endtask

   initial begin
      test_reset;
      test_move;
      test_range;
      test_timeout;
      test_random;
      test_drop;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
